// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  localparam int unsigned DATA_W        = 64;
  localparam int unsigned REG_IDX_W     = 5;
  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned WB_FIFO_DEPTH = 2;
  localparam int unsigned PERF_W        = 32;

  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  // One register write request: destination, value, SP/XZR selector for index 31.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
    logic                 wr_sp;
  } wb_req_t;

  // True when the request targets the zero register and must be dropped.
  function automatic logic is_xzr_write(input wb_req_t req);
    return (req.rd == XZR_IDX) && !req.wr_sp;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous skid FIFO of write requests with an age-ordered peek bus
// (index 0 = oldest) used for the pending mask and the bypass lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  wb_req_t                        push_data,
  input  logic                           pop,
  output wb_req_t                        head,
  output logic [$clog2(DEPTH):0]         count,
  output wb_req_t [DEPTH-1:0]            peek,
  output logic [DEPTH-1:0]               peek_vld
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full;
  logic                do_push;
  logic                do_pop;

  // Next-state: pop frees the head slot, so a push is legal even when full.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Age-ordered view of the stored entries.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      peek[i]     = mem_q[rd_ptr_q + PTR_W'(i)];
      peek_vld[i] = (CNT_W'(i) < count_q);
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges load returns and ALU results onto one register-file
// write port, drops XZR writes, and exposes pending destinations for bypass.
// Optional performance counters are built when WB_PERF_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 alu_wr_sp,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_wr_sp,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] write_register,
  output logic [DATA_W-1:0]    write_d,
  output logic [NUM_REGS-1:0]  pending_mask,
  input  logic [REG_IDX_W-1:0] lk_rd,
  output logic                 lk_hit,
  output logic [DATA_W-1:0]    lk_data,
  output logic [PERF_W-1:0]    perf_wr_cnt,
  output logic [PERF_W-1:0]    perf_stall_cnt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_req_t                  alu_req, ld_req, win_req, fifo_head;
  wb_req_t [FIFO_DEPTH-1:0] fifo_peek;
  logic [FIFO_DEPTH-1:0]    fifo_peek_vld;
  logic [CNT_W-1:0]         fifo_count;
  logic                     alu_acc, alu_ok, ld_ok, win_vld, fifo_push, fifo_pop;
  logic [NUM_REGS-1:0]      pend;
  logic                     hit;
  logic [DATA_W-1:0]        hit_data;

  logic                 reg_write_q, reg_write_d;
  logic [REG_IDX_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0]    write_d_q, write_d_d;

  // Acceptance depends only on FIFO occupancy; held low during reset.
  assign alu_ready = reset_n && (fifo_count < CNT_W'(FIFO_DEPTH));

  // Write-slot arbitration: load, then FIFO head, then direct ALU.
  always_comb begin
    alu_req     = '{rd: alu_rd, data: alu_data, wr_sp: alu_wr_sp};
    ld_req      = '{rd: ld_rd, data: ld_data, wr_sp: ld_wr_sp};
    alu_acc     = alu_valid && alu_ready;
    alu_ok      = alu_acc && !is_xzr_write(alu_req);
    ld_ok       = ld_valid && !is_xzr_write(ld_req);
    win_vld     = 1'b0;
    win_req     = '0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    if (ld_ok) begin
      win_vld   = 1'b1;
      win_req   = ld_req;
      fifo_push = alu_ok;
    end else if (fifo_count != '0) begin
      win_vld   = 1'b1;
      win_req   = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = alu_ok;
    end else if (alu_ok) begin
      win_vld   = 1'b1;
      win_req   = alu_req;
    end
    reg_write_d      = win_vld;
    write_register_d = win_vld ? win_req.rd : write_register_q;
    write_d_d        = win_vld ? win_req.data : write_d_q;
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_d_q        <= '0;
    end else begin
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_d_q        <= write_d_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign write_register = write_register_q;
  assign write_d        = write_d_q;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (alu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .peek      (fifo_peek),
    .peek_vld  (fifo_peek_vld)
  );

  // Pending mask and bypass lookup from start-of-cycle state; output reg wins over FIFO, youngest FIFO entry wins.
  always_comb begin
    pend     = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_peek_vld[i]) begin
        pend[fifo_peek[i].rd] = 1'b1;
        if (fifo_peek[i].rd == lk_rd) begin
          hit      = 1'b1;
          hit_data = fifo_peek[i].data;
        end
      end
    end
    if (reg_write_q) begin
      pend[write_register_q] = 1'b1;
      if (write_register_q == lk_rd) begin
        hit      = 1'b1;
        hit_data = write_d_q;
      end
    end
    pending_mask = reset_n ? pend : '0;
    lk_hit       = reset_n && hit;
    lk_data      = lk_hit ? hit_data : '0;
  end

`ifdef WB_PERF_EN
  logic [PERF_W-1:0] perf_wr_q, perf_wr_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Saturating event counters.
  always_comb begin
    perf_wr_d    = perf_wr_q;
    perf_stall_d = perf_stall_q;
    if (reg_write_q && (perf_wr_q != '1)) begin
      perf_wr_d = perf_wr_q + PERF_W'(1);
    end
    if (alu_valid && !alu_ready && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + PERF_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_wr_q    <= perf_wr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_wr_cnt    = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage.
module tb_wb_stage;
  import wb_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 alu_valid, alu_ready, alu_wr_sp;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 ld_valid, ld_wr_sp;
  logic [REG_IDX_W-1:0] ld_rd;
  logic [DATA_W-1:0]    ld_data;
  logic                 reg_write;
  logic [REG_IDX_W-1:0] write_register;
  logic [DATA_W-1:0]    write_d;
  logic [NUM_REGS-1:0]  pending_mask;
  logic [REG_IDX_W-1:0] lk_rd;
  logic                 lk_hit;
  logic [DATA_W-1:0]    lk_data;
  logic [PERF_W-1:0]    perf_wr_cnt, perf_stall_cnt;

  int checks   = 0;
  int failures = 0;
  int ld_run   = 0;
  int rule_viol = 0;
  int exp_wr_perf;
  int exp_stall_perf;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_wr_sp      (alu_wr_sp),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_wr_sp       (ld_wr_sp),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_d        (write_d),
    .pending_mask   (pending_mask),
    .lk_rd          (lk_rd),
    .lk_hit         (lk_hit),
    .lk_data        (lk_data),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_wr_sp = 1'b0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0; ld_wr_sp  = 1'b0;
  endtask

  // Upstream rules: load-free cycle at least every 8 cycles; no duplicate in-flight destination.
  always @(posedge clk) begin
    if (!reset_n) begin
      ld_run = 0;
    end else begin
      ld_run = ld_valid ? ld_run + 1 : 0;
      if (ld_run > 7) rule_viol++;
      if (alu_valid && alu_ready && !(alu_rd == XZR_IDX && !alu_wr_sp) && pending_mask[alu_rd]) rule_viol++;
      if (ld_valid && !(ld_rd == XZR_IDX && !ld_wr_sp) && pending_mask[ld_rd]) rule_viol++;
      if (ld_valid && alu_valid && alu_ready && ld_rd == alu_rd && ld_rd != XZR_IDX) rule_viol++;
    end
  end

  initial begin
`ifdef WB_PERF_EN
    exp_wr_perf = 9; exp_stall_perf = 2;
`else
    exp_wr_perf = 0; exp_stall_perf = 0;
`endif
    reset_n = 1'b0;
    lk_rd   = '0;
    idle();
    tick(); tick();
    chk("rst_reg_write", reg_write, 0);
    chk("rst_wr_reg", write_register, 0);
    chk("rst_wr_d", write_d, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_perf_wr", perf_wr_cnt, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_alu_ready", alu_ready, 1);

    // 1: lone ALU write
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA5;
    tick(); idle();
    chk("t1_reg_write", reg_write, 1);
    chk("t1_wr_reg", write_register, 3);
    chk("t1_wr_d", write_d, 64'hA5);
    chk("t1_pending", pending_mask, 32'h8);
    tick();
    chk("t1_done", reg_write, 0);
    chk("t1_pend_clr", pending_mask, 0);

    // 2: ALU/load collision
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 64'h22;
    #1;
    chk("t2_ready0", alu_ready, 1);
    tick(); idle();
    chk("t2_c1_wr_reg", write_register, 2);
    chk("t2_c1_wr_d", write_d, 64'h22);
    chk("t2_c1_pending", pending_mask, 32'h6);
    chk("t2_ready1", alu_ready, 1);
    tick();
    chk("t2_c2_we", reg_write, 1);
    chk("t2_c2_wr_reg", write_register, 1);
    chk("t2_c2_wr_d", write_d, 64'h11);
    tick();
    chk("t2_done", reg_write, 0);

    // 3: load burst starves ALU
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = REG_IDX_W'(10 + i); ld_data = 64'(32'h100 + i);
      alu_valid = 1'b1;
      alu_rd   = (i == 0) ? 5'd20 : (i == 1) ? 5'd21 : 5'd22;
      alu_data = (i == 0) ? 64'h200 : (i == 1) ? 64'h201 : 64'h202;
      #1;
      chk("t3_ready", alu_ready, (i < 2) ? 1 : 0);
      if (i == 2) chk("t3_pending", pending_mask, 32'h0030_0800);
      tick();
      chk("t3_ld_wr_reg", write_register, 64'(10 + i));
      chk("t3_ld_wr_d", write_d, 64'(32'h100 + i));
    end
    idle();
    tick();
    chk("t3_f0_wr_reg", write_register, 20);
    chk("t3_f0_wr_d", write_d, 64'h200);
    tick();
    chk("t3_f1_we", reg_write, 1);
    chk("t3_f1_wr_reg", write_register, 21);
    chk("t3_f1_wr_d", write_d, 64'h201);
    tick();
    chk("t3_done", reg_write, 0);
    chk("t3_perf_wr", perf_wr_cnt, 64'(exp_wr_perf));
    chk("t3_perf_stall", perf_stall_cnt, 64'(exp_stall_perf));

    // 4: XZR discard, SP write
    alu_valid = 1'b1; alu_rd = 5'd31; alu_wr_sp = 1'b0; alu_data = 64'hDEAD;
    ld_valid  = 1'b1; ld_rd  = 5'd31; ld_wr_sp  = 1'b0; ld_data  = 64'hBEEF;
    #1;
    chk("t4_xzr_ready", alu_ready, 1);
    tick(); idle();
    chk("t4_xzr_no_we", reg_write, 0);
    chk("t4_xzr_pend", pending_mask, 0);
    ld_valid = 1'b1; ld_rd = 5'd31; ld_wr_sp = 1'b1; ld_data = 64'h8000;
    tick(); idle();
    chk("t4_sp_we", reg_write, 1);
    chk("t4_sp_wr_reg", write_register, 31);
    chk("t4_sp_wr_d", write_d, 64'h8000);
    chk("t4_sp_pend", pending_mask, 32'h8000_0000);
    tick();

    // 5: bypass lookup
    ld_valid  = 1'b1; ld_rd  = 5'd5; ld_data  = 64'h77;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h55;
    tick(); idle();
    lk_rd = 5'd7; #1;
    chk("t5_fifo_hit", lk_hit, 1);
    chk("t5_fifo_data", lk_data, 64'h55);
    lk_rd = 5'd8; #1;
    chk("t5_miss_hit", lk_hit, 0);
    chk("t5_miss_data", lk_data, 0);
    lk_rd = 5'd5; #1;
    chk("t5_out_data", lk_data, 64'h77);
    tick();
    lk_rd = 5'd7; #1;
    chk("t5_outreg_hit", lk_hit, 1);
    chk("t5_outreg_data", lk_data, 64'h55);
    tick();
    chk("t5_written_hit", lk_hit, 0);

    // 6: reset with a full FIFO
    ld_valid = 1'b1; ld_rd = 5'd12; alu_valid = 1'b1; alu_rd = 5'd14;
    tick();
    ld_rd = 5'd13; alu_rd = 5'd15;
    tick(); idle();
    chk("t6_full_ready", alu_ready, 0);
    reset_n = 1'b0; #1;
    chk("t6_rst_ready", alu_ready, 0);
    chk("t6_rst_pend", pending_mask, 0);
    tick();
    chk("t6_rst_we", reg_write, 0);
    reset_n = 1'b1; #1;
    chk("t6_rel_ready", alu_ready, 1);
    chk("t6_rel_pend", pending_mask, 0);
    chk("t6_perf_wr", perf_wr_cnt, 0);
    chk("t6_perf_stall", perf_stall_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", reg_write, 0);
    end

    chk("upstream_rules", 64'(rule_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
